// File: rtl/nds_dma_fifo_burst_drain.sv
// Pop-side DMA drain engine: splits a transfer into bursts and streams FIFO beats.
// Optional abort port enabled by defining NDS_DMA_DRAIN_ABORT_EN.
module nds_dma_fifo_burst_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   parameter int CNT_WIDTH  = 16,
   parameter int LEN_WIDTH  = $clog2(MAX_BURST) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  xfer_len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic                  fifo_almost_empty,
   output logic                  req,
   output logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  req_ack,
   output logic                  dat_valid,
   output logic [DATA_WIDTH-1:0] dat_data,
   output logic                  dat_last,
   input  logic                  dat_ready
`ifdef NDS_DMA_DRAIN_ABORT_EN
   ,
   input  logic                  abort
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REQ,
      S_DATA
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAXB_C = CNT_WIDTH'(MAX_BURST);
   localparam logic [LEN_WIDTH-1:0] MAXB_L = LEN_WIDTH'(MAX_BURST);
   localparam logic [LEN_WIDTH-1:0] ONE_L  = LEN_WIDTH'(1);

   state_t               state;
   state_t               state_nx;
   logic [CNT_WIDTH-1:0] remaining;
   logic [CNT_WIDTH-1:0] remaining_nx;
   logic [CNT_WIDTH-1:0] rem_sub;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic [LEN_WIDTH-1:0] beat_cnt_nx;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] len_nx;
   logic [LEN_WIDTH-1:0] blen;
   logic                 done_q;
   logic                 done_nx;
   logic                 abort_in;
   logic                 abort_pend;
   logic                 abort_pend_nx;
   logic                 hs;

`ifdef NDS_DMA_DRAIN_ABORT_EN
   assign abort_in = abort;
`else
   assign abort_in = 1'b0;
`endif

   // Output decode: beat channel is combinational on FIFO emptiness
   assign busy      = (state != S_IDLE);
   assign req       = (state == S_REQ);
   assign req_len   = len_q;
   assign done      = done_q;
   assign dat_valid = (state == S_DATA) && !fifo_empty;
   assign dat_data  = fifo_rd_data;
   assign dat_last  = dat_valid && (beat_cnt == ONE_L);
   assign fifo_rd   = dat_valid && dat_ready;
   assign hs        = fifo_rd;
   assign rem_sub   = remaining - CNT_WIDTH'(len_q);

   // Burst length: the smaller of what is left and the burst cap
   always_comb begin
      blen = MAXB_L;
      if (remaining < MAXB_C) begin
         blen = remaining[LEN_WIDTH-1:0];
      end
   end

   // State register and transfer bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         remaining  <= '0;
         beat_cnt   <= '0;
         len_q      <= '0;
         done_q     <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         state      <= state_nx;
         remaining  <= remaining_nx;
         beat_cnt   <= beat_cnt_nx;
         len_q      <= len_nx;
         done_q     <= done_nx;
         abort_pend <= abort_pend_nx;
      end
   end

   // Next-state logic for the IDLE/WAIT/REQ/DATA sequence
   always_comb begin
      state_nx      = state;
      remaining_nx  = remaining;
      beat_cnt_nx   = beat_cnt;
      len_nx        = len_q;
      done_nx       = 1'b0;
      abort_pend_nx = abort_pend;
      unique case (state)
         S_IDLE: begin
            abort_pend_nx = 1'b0;
            if (start) begin
               if (xfer_len != '0) begin
                  remaining_nx = xfer_len;
                  state_nx     = S_WAIT;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (abort_in) begin
               remaining_nx = '0;
               done_nx      = 1'b1;
               state_nx     = S_IDLE;
            end else if (!fifo_empty &&
                         ((blen != MAXB_L) || !fifo_almost_empty)) begin
               len_nx   = blen;
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            if (req_ack) begin
               beat_cnt_nx   = len_q;
               abort_pend_nx = abort_in;
               state_nx      = S_DATA;
            end else if (abort_in) begin
               remaining_nx = '0;
               done_nx      = 1'b1;
               state_nx     = S_IDLE;
            end
         end
         S_DATA: begin
            if (abort_in) begin
               abort_pend_nx = 1'b1;
            end
            if (hs) begin
               beat_cnt_nx = beat_cnt - ONE_L;
               if (beat_cnt == ONE_L) begin
                  if (rem_sub == '0 || abort_pend || abort_in) begin
                     remaining_nx = '0;
                     done_nx      = 1'b1;
                     state_nx     = S_IDLE;
                  end else begin
                     remaining_nx = rem_sub;
                     state_nx     = S_WAIT;
                  end
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nds_dma_fifo_burst_drain.sv
// Scoreboard bench for nds_dma_fifo_burst_drain with a queue-backed FIFO model.
// Abort scenarios are exercised when NDS_DMA_DRAIN_ABORT_EN is defined.
module tb_nds_dma_fifo_burst_drain;

   localparam int DW = 32;
   localparam int MB = 4;
   localparam int CW = 16;
   localparam int LW = $clog2(MB) + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] xfer_len = '0;
   logic          busy;
   logic          done;
   logic          fifo_rd;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic          fifo_almost_empty;
   logic          req;
   logic [LW-1:0] req_len;
   logic          req_ack = 1'b0;
   logic          dat_valid;
   logic [DW-1:0] dat_data;
   logic          dat_last;
   logic          dat_ready = 1'b1;
`ifdef NDS_DMA_DRAIN_ABORT_EN
   logic          abort = 1'b0;
`endif

   // FIFO model
   logic [DW-1:0] mem [0:255];
   logic [31:0]   wr_ptr = 0;
   logic [31:0]   rd_ptr = 0;
   logic [31:0]   fcount;

   assign fcount            = wr_ptr - rd_ptr;
   assign fifo_empty        = (fcount == 0);
   assign fifo_almost_empty = (fcount <= MB - 1);
   assign fifo_rd_data      = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (fifo_rd) rd_ptr <= rd_ptr + 1;
   end

   // Scoreboard state
   logic [DW-1:0] exp_data[$];
   bit            exp_last[$];
   int            exp_len[$];
   int            exp_done = 0;
   int            errors = 0;
   int            checks = 0;
   int            beats_seen = 0;
   int            done_cnt = 0;
   int            pop_cnt = 0;
   int            ack_dly = 1;
   bit            ack_en = 1'b1;
   bit            rand_rdy = 1'b0;

   nds_dma_fifo_burst_drain #(
      .DATA_WIDTH(DW),
      .MAX_BURST(MB),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .xfer_len(xfer_len),
      .busy(busy),
      .done(done),
      .fifo_rd(fifo_rd),
      .fifo_rd_data(fifo_rd_data),
      .fifo_empty(fifo_empty),
      .fifo_almost_empty(fifo_almost_empty),
      .req(req),
      .req_len(req_len),
      .req_ack(req_ack),
      .dat_valid(dat_valid),
      .dat_data(dat_data),
      .dat_last(dat_last),
      .dat_ready(dat_ready)
`ifdef NDS_DMA_DRAIN_ABORT_EN
      ,
      .abort(abort)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic push();
      logic [DW-1:0] w;
      w = $urandom;
      mem[wr_ptr[7:0]] = w;
      exp_data.push_back(w);
      wr_ptr = wr_ptr + 1;
   endtask

   // Reference: beats are FIFO order; last every MB beats and at the end
   task automatic expect_xfer(input int len);
      for (int i = 0; i < len; i++)
         exp_last.push_back(((i % MB) == MB - 1) || (i == len - 1));
      for (int b = 0; b < len; b += MB)
         exp_len.push_back((len - b) < MB ? (len - b) : MB);
      exp_done++;
   endtask

   task automatic do_start(input int len);
      @(posedge clk); #1;
      start    = 1'b1;
      xfer_len = CW'(len);
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s: got no done within %0d cycles, required done",
                  nm, budget);
      end
   endtask

   task automatic wait_beats(input int target, input int budget);
      int n = 0;
      while (beats_seen < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (beats_seen < target) begin
         errors++;
         $display("FAIL beat_timeout: got %0d beats, required %0d",
                  beats_seen, target);
      end
   endtask

   // Monitor: compare presented outputs against the scoreboard queues
   always @(negedge clk) begin
      logic [DW-1:0] ed;
      bit            el;
      int            ln;
      chk("rd_when_empty", {63'd0, fifo_rd & fifo_empty}, 0);
      chk("valid_when_empty", {63'd0, dat_valid & fifo_empty}, 0);
      if (fifo_rd) pop_cnt++;
      if (dat_valid && dat_ready) begin
         beats_seen++;
         if (exp_data.size() == 0 || exp_last.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL beat_unexpected: got beat %0h, required none",
                     dat_data);
         end else begin
            ed = exp_data.pop_front();
            el = exp_last.pop_front();
            chk("beat_data", dat_data, ed);
            chk("beat_last", {63'd0, dat_last}, {63'd0, el});
         end
      end
      if (req && req_ack) begin
         if (exp_len.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL req_unexpected: got req_len %0d, required none",
                     req_len);
         end else begin
            ln = exp_len.pop_front();
            chk("req_len", {61'd0, req_len}, 64'(ln));
         end
      end
      if (done) begin
         done_cnt++;
         chk("done_expected", {63'd0, exp_done > 0}, 1);
         chk("done_busy", {63'd0, busy}, 0);
         if (exp_done > 0) exp_done--;
      end
   end

   // Burst request acknowledger with programmable delay
   initial begin
      int ack_wait = 0;
      forever begin
         @(posedge clk); #1;
         if (req_ack) begin
            req_ack  = 1'b0;
            ack_wait = 0;
         end else if (req && ack_en) begin
            if (ack_wait >= ack_dly) req_ack = 1'b1;
            else ack_wait++;
         end
      end
   end

   // Beat sink backpressure
   initial begin
      forever begin
         @(posedge clk); #1;
         dat_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int k;
      int pushed;
      int b0;
      int p0;
      int n;

      // Reset with a pre-filled FIFO
      for (int i = 0; i < 8; i++) push();
      repeat (3) begin
         @(negedge clk);
         chk("rst_req", {63'd0, req}, 0);
         chk("rst_valid", {63'd0, dat_valid}, 0);
         chk("rst_rd", {63'd0, fifo_rd}, 0);
         chk("rst_busy", {63'd0, busy}, 0);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req", {63'd0, req}, 0);
      chk("post_rst_valid", {63'd0, dat_valid}, 0);
      chk("post_rst_rd", {63'd0, fifo_rd}, 0);
      chk("post_rst_busy", {63'd0, busy}, 0);
      chk("post_rst_done", {63'd0, done}, 0);

      // Ten beats split 4/4/2, with a start while busy that must be ignored
      push();
      push();
      ack_dly = 1;
      expect_xfer(10);
      do_start(10);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_during", {63'd0, busy}, 1);
      start    = 1'b1;
      xfer_len = CW'(5);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t2_done", 200);
      @(negedge clk);
      chk("t2_busy_after", {63'd0, busy}, 0);

      // Full burst waits until the FIFO holds MB words
      expect_xfer(4);
      push();
      push();
      do_start(4);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("t3_hold_req", {63'd0, req}, 0);
      chk("t3_hold_busy", {63'd0, busy}, 1);
      @(posedge clk); #1;
      push();
      push();
      wait_done("t3_done", 200);

      // Short burst stalls mid-way when the FIFO runs dry
      expect_xfer(3);
      push();
      b0 = beats_seen;
      do_start(3);
      wait_beats(b0 + 1, 200);
      repeat (5) @(posedge clk);
      #1;
      chk("t4_gap_valid", {63'd0, dat_valid}, 0);
      push();
      @(posedge clk); #1;
      push();
      wait_done("t4_done", 200);
      chk("t4_beats", 64'(beats_seen - b0), 3);

      // Zero-length transfer
      exp_done++;
      do_start(0);
      @(negedge clk);
      chk("t5_done", {63'd0, done}, 1);
      chk("t5_busy", {63'd0, busy}, 0);
      chk("t5_req", {63'd0, req}, 0);
      @(negedge clk);
      chk("t5_done_pulse", {63'd0, done}, 0);

`ifdef NDS_DMA_DRAIN_ABORT_EN
      // Abort during burst 1 completes that burst only
      for (int i = 0; i < 8; i++) push();
      for (int i = 0; i < 4; i++) exp_last.push_back(i == 3);
      exp_len.push_back(4);
      exp_done++;
      b0 = beats_seen;
      do_start(8);
      wait_beats(b0 + 1, 200);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_done("t6a_done", 200);
      repeat (4) @(posedge clk);
      #1;
      chk("t6a_left", 64'(fcount), 4);
      chk("t6a_beats", 64'(beats_seen - b0), 4);

      // Abort while the request is pending
      ack_en = 1'b0;
      exp_done++;
      p0 = pop_cnt;
      do_start(4);
      n = 0;
      while (!req && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t6b_req_seen", {63'd0, req}, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("t6b_done", {63'd0, done}, 1);
      chk("t6b_busy", {63'd0, busy}, 0);
      chk("t6b_pops", 64'(pop_cnt - p0), 0);
      ack_en = 1'b1;
      expect_xfer(4);
      do_start(4);
      wait_done("t6b_drain", 200);
`endif

      // Randomized transfers with backpressure and trickled data
      rand_rdy = 1'b1;
      for (int t = 0; t < 12; t++) begin
         len     = $urandom_range(0, 14);
         ack_dly = $urandom_range(0, 2);
         k       = $urandom_range(0, len);
         expect_xfer(len);
         for (int i = 0; i < k; i++) push();
         pushed = k;
         do_start(len);
         while (pushed < len) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 1) begin
               push();
               pushed++;
            end
         end
         wait_done("rand_done", 400);
      end
      rand_rdy = 1'b0;

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("end_data_q", 64'(exp_data.size()), 0);
      chk("end_last_q", 64'(exp_last.size()), 0);
      chk("end_len_q", 64'(exp_len.size()), 0);
      chk("end_done_q", 64'(exp_done), 0);
      chk("end_busy", {63'd0, busy}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
